// File: rtl/vga_timing.sv
// ----------------------------------------------------------------------------
// vga_timing
//   VGA raster timing generator with an elapsed-seconds timer derived from
//   the frame rate.
//
//   Ports
//     clk          in   pixel clock (only clock)
//     rst_n        in   synchronous active-low reset
//     run          in   1 lets the seconds timer advance on each frame start
//     clear        in   synchronous zero of the seconds timer (beats run)
//     col[9:0]     out  current pixel column
//     row[9:0]     out  current line
//     visible      out  pixel is inside the active area
//     hsync        out  active-low horizontal sync
//     vsync        out  active-low vertical sync
//     frame_start  out  one-cycle pulse at col=0, row=0
//     seconds_o    out  elapsed seconds, 0..59
//
//   Handshake: none. All inputs are level-sampled on every rising clk edge;
//   there is no valid/ready pairing on this block.
// ----------------------------------------------------------------------------
module vga_timing #(
  parameter int H_VISIBLE      = 640,
  parameter int H_FRONT        = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BACK         = 48,
  parameter int V_VISIBLE      = 480,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clear,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [5:0] seconds_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int FW      = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [5:0]    SEC_LAST   = 6'd59;

  logic [9:0]    col_q, col_d;
  logic [9:0]    row_q, row_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [5:0]    sec_q, sec_d;

  logic col_wrap;
  logic hs_active;
  logic vs_active;

  // Raster counters: col runs every clock, row steps on each col wrap.
  always_comb begin
    col_wrap = (col_q == H_LAST);
    col_d    = col_wrap ? 10'd0 : col_q + 10'd1;
    row_d    = row_q;
    if (col_wrap) begin
      row_d = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
    end
  end

  // Outputs are decoded straight from the counters so they line up with
  // col/row with no extra latency. Gating with rst_n forces the idle levels
  // while reset is held, and a mid-frame reset cuts any sync pulse at once.
  always_comb begin
    hs_active   = (col_q >= HS_FIRST) && (col_q <= HS_LAST);
    vs_active   = (row_q >= VS_FIRST) && (row_q <= VS_LAST);
    visible     = rst_n && (col_q < H_VIS) && (row_q < V_VIS);
    hsync       = !(rst_n && hs_active);
    vsync       = !(rst_n && vs_active);
    frame_start = rst_n && (col_q == 10'd0) && (row_q == 10'd0);
  end

  // Seconds timer: clear beats run; the frame counter only moves on a
  // frame start, and rolling it over carries into the seconds register.
  always_comb begin
    frame_d = frame_q;
    sec_d   = sec_q;
    if (clear) begin
      frame_d = '0;
      sec_d   = 6'd0;
    end else if (run && frame_start) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        sec_d   = (sec_q == SEC_LAST) ? 6'd0 : sec_q + 6'd1;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= 10'd0;
      row_q   <= 10'd0;
      frame_q <= '0;
      sec_q   <= 6'd0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      frame_q <= frame_d;
      sec_q   <= sec_d;
    end
  end

  assign col       = col_q;
  assign row       = row_q;
  assign seconds_o = sec_q;

endmodule
